mem_reduce_ctrl: RTL and testbench
==================================

Name: mem_reduce_ctrl

Overview:
- Sequencer that sits directly in front of the 16x16 data RAM and drives its address and control pins.
- On `start` it:
  - pulses the RAM's file-load strobe;
  - reads COUNT consecutive words from BASE_ADDR;
  - tracks the unsigned maximum and its address;
  - writes the maximum to RESULT_ADDR;
  - pulses the RAM's file-dump strobe;
  - signals `done`.
- The RAM read is combinational, so one word is consumed per cycle.

Parameters:
- MEMSIZE, 16, data word width; matches the RAM word width.
- ADDRESSSIZE, 4, RAM address width.
- BASE_ADDR, 0, first address scanned.
- COUNT, 15, number of words scanned; legal range 1..2^ADDRESSSIZE. BASE_ADDR+COUNT-1 must not exceed 2^ADDRESSSIZE-1.
- RESULT_ADDR, 15, address that receives the maximum.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a run; sampled in IDLE only.
- readData  input  MEMSIZE  RAM read data, valid in the same cycle as enRead.
- address  output  ADDRESSSIZE  RAM address.
- writeData  output  MEMSIZE  RAM write data.
- enWrite  output  1  RAM write enable.
- enRead  output  1  RAM read enable.
- readFile  output  1  RAM file-load strobe.
- writeFile  output  1  RAM file-dump strobe.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- max_value  output  MEMSIZE  registered maximum found.
- max_index  output  ADDRESSSIZE  registered address of the maximum.

Behaviour:
- Reset:
  - rst asserts asynchronously and forces state IDLE.
  - Every output and internal register goes to 0: address, writeData, enWrite, enRead, readFile, writeFile, busy, done, max_value, max_index, scan counter.
- Output timing: all RAM-side outputs are decoded only from registered state and counter, so they carry no combinational path from `start` or `readData`.
- States: IDLE -> LOAD -> READ -> WRITE -> DUMP -> DONE -> IDLE.
- IDLE:
  - All strobes are 0.
  - If start=1 at a clock edge, go to LOAD.
  - max_value and max_index keep the previous run's result until LOAD.
- LOAD (1 cycle):
  - readFile=1.
  - Clear max_value to 0 and max_index to BASE_ADDR.
  - Load scan counter with 0.
  - Go to READ.
- READ (exactly COUNT cycles):
  - enRead=1, address = BASE_ADDR + counter.
  - At each edge, if readData > max_value (unsigned, strict), capture max_value = readData and max_index = address.
  - Ties keep the lower address.
  - Because the registers clear to 0, an all-zero scan gives max_value=0 and max_index=BASE_ADDR.
  - The counter increments each cycle; on the edge where counter = COUNT-1, go to WRITE.
  - The address computation is ADDRESSSIZE bits wide with no wrap. The parameter constraint guarantees no overflow.
- WRITE (1 cycle):
  - enWrite=1, address=RESULT_ADDR, writeData=max_value (value after the last READ update).
  - enRead=0.
- DUMP (1 cycle): writeFile=1, address=RESULT_ADDR; go to DONE.
- DONE (1 cycle): done=1; go to IDLE.
- Latency: start sampled at edge E gives done high during cycle E+COUNT+4 (LOAD, COUNT READs, WRITE, DUMP, DONE).
- Start handling:
  - start is ignored outside IDLE; there is no queueing.
  - start held high re-launches on the edge after DONE.
- Strobe exclusivity: enRead, enWrite, readFile and writeFile are mutually exclusive and never high together.
- Reset mid-run:
  - Immediate return to IDLE; all outputs go to 0.
  - No write to RAM occurs after rst rises.
- Result overlap: if RESULT_ADDR lies inside the scan range, the old contents are scanned first; the write happens after the scan.

Optional Feature:
- Macro: MEM_REDUCE_SUM_EN.
- When defined:
  - Adds output `sum_value` (MEMSIZE).
  - Accumulates a saturating unsigned sum of every word read in READ. The sum clears in LOAD and clamps at 2^MEMSIZE-1.
  - Adds a WRITE_SUM state between WRITE and DUMP: enWrite=1, address=RESULT_ADDR+1 (mod 2^ADDRESSSIZE), writeData=sum_value.
  - Latency grows by 1 cycle.
- When undefined: no sum logic, no sum_value port, and timing as above.

Test Plan:
- Reset, then start with RAM words 0..14 = 0x0003, 0x00A0, 0x0010, rest 0x0000 -> readFile pulse at cycle 1; enRead for 15 cycles at addresses 0..14; then enWrite with address=15 and writeData=0x00A0; max_index=1; writeFile pulse; done at cycle 19.
- Words 2 and 9 both 0xFFFF, others smaller -> max_index=2, max_value=0xFFFF (tie keeps lower address).
- All words 0x0000 -> max_value=0, max_index=BASE_ADDR=0; memory[15] written with 0.
- Assert start again during READ, and hold start high through DONE -> no restart mid-run; a new LOAD begins on the edge after DONE.
- Assert rst on the 5th READ cycle -> all outputs 0 immediately; memory[15] unchanged; a later start runs cleanly.
- With MEM_REDUCE_SUM_EN defined, fifteen words of 0x2000 -> sum saturates to 0xFFFF; memory[0] (address 15+1 wrapped) receives 0xFFFF; done at cycle 20.

Source files
------------

// File: rtl/mem_reduce_ctrl.sv
// Scans COUNT words of the data RAM, tracks the unsigned maximum and its
// address, writes it back to RESULT_ADDR. Optional MEM_REDUCE_SUM_EN adds a saturating sum.
module mem_reduce_ctrl #(
    parameter int MEMSIZE     = 16,
    parameter int ADDRESSSIZE = 4,
    parameter int BASE_ADDR   = 0,
    parameter int COUNT       = 15,
    parameter int RESULT_ADDR = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [MEMSIZE-1:0]     readData,
    output logic [ADDRESSSIZE-1:0] address,
    output logic [MEMSIZE-1:0]     writeData,
    output logic                   enWrite,
    output logic                   enRead,
    output logic                   readFile,
    output logic                   writeFile,
    output logic                   busy,
    output logic                   done,
`ifdef MEM_REDUCE_SUM_EN
    output logic [MEMSIZE-1:0]     sum_value,
`endif
    output logic [MEMSIZE-1:0]     max_value,
    output logic [ADDRESSSIZE-1:0] max_index
);

    // state     | meaning
    // IDLE      | waiting for start, all strobes low
    // LOAD      | readFile pulse, clear max and counter
    // READ      | COUNT cycles, one word consumed per cycle
    // WRITE     | maximum written to RESULT_ADDR
    // WRITE_SUM | saturated sum written to RESULT_ADDR+1 (optional)
    // DUMP      | writeFile pulse
    // DONE      | one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        WRITE,
`ifdef MEM_REDUCE_SUM_EN
        WRITE_SUM,
`endif
        DUMP,
        DONE
    } state_t;

    localparam int CW = ADDRESSSIZE + 1;
    localparam logic [ADDRESSSIZE-1:0] BASE_A   = ADDRESSSIZE'(BASE_ADDR);
    localparam logic [ADDRESSSIZE-1:0] RESULT_A = ADDRESSSIZE'(RESULT_ADDR);
    localparam logic [CW-1:0]          LAST_CNT = CW'(COUNT - 1);

    state_t                 state;
    logic [CW-1:0]          scanCnt;
    logic [MEMSIZE-1:0]     newMax;
    logic [ADDRESSSIZE-1:0] nextReadAddr;

    // Strict compare so ties keep the lower (earlier) address.
    always_comb begin
        newMax = max_value;
        if (readData > max_value)
            newMax = readData;
    end

    assign nextReadAddr = BASE_A + scanCnt[ADDRESSSIZE-1:0] + ADDRESSSIZE'(1);

`ifdef MEM_REDUCE_SUM_EN
    logic [MEMSIZE:0]   sumWide;
    logic [MEMSIZE-1:0] sumNext;

    always_comb begin
        sumWide = {1'b0, sum_value} + {1'b0, readData};
        sumNext = sumWide[MEMSIZE-1:0];
        if (sumWide[MEMSIZE])
            sumNext = '1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            scanCnt   <= '0;
            address   <= '0;
            writeData <= '0;
            enWrite   <= 1'b0;
            enRead    <= 1'b0;
            readFile  <= 1'b0;
            writeFile <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            max_value <= '0;
            max_index <= '0;
`ifdef MEM_REDUCE_SUM_EN
            sum_value <= '0;
`endif
        end else begin
            enWrite   <= 1'b0;
            enRead    <= 1'b0;
            readFile  <= 1'b0;
            writeFile <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        readFile <= 1'b1;
                        busy     <= 1'b1;
                        address  <= '0;
                    end
                end
                LOAD: begin
                    max_value <= '0;
                    max_index <= BASE_A;
                    scanCnt   <= '0;
`ifdef MEM_REDUCE_SUM_EN
                    sum_value <= '0;
`endif
                    state     <= READ;
                    enRead    <= 1'b1;
                    address   <= BASE_A;
                end
                READ: begin
                    if (readData > max_value) begin
                        max_value <= readData;
                        max_index <= address;
                    end
`ifdef MEM_REDUCE_SUM_EN
                    sum_value <= sumNext;
`endif
                    scanCnt <= scanCnt + CW'(1);
                    if (scanCnt == LAST_CNT) begin
                        state     <= WRITE;
                        enWrite   <= 1'b1;
                        address   <= RESULT_A;
                        writeData <= newMax;
                    end else begin
                        enRead  <= 1'b1;
                        address <= nextReadAddr;
                    end
                end
                WRITE: begin
`ifdef MEM_REDUCE_SUM_EN
                    state     <= WRITE_SUM;
                    enWrite   <= 1'b1;
                    address   <= RESULT_A + ADDRESSSIZE'(1);
                    writeData <= sum_value;
                end
                WRITE_SUM: begin
`endif
                    state     <= DUMP;
                    writeFile <= 1'b1;
                    address   <= RESULT_A;
                end
                DUMP: begin
                    state   <= DONE;
                    done    <= 1'b1;
                    address <= '0;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_reduce_ctrl.sv
// Self-checking bench for mem_reduce_ctrl: a behavioural RAM plus a reference
// model of the expected max/index/sum and the cycle-by-cycle strobe schedule.
module tb_mem_reduce_ctrl;

    localparam int BASE  = 0;
    localparam int COUNT = 15;
    localparam int RES   = 15;
`ifdef MEM_REDUCE_SUM_EN
    localparam int SUMX = 1;
`else
    localparam int SUMX = 0;
`endif
    localparam int LAT   = COUNT + 4 + SUMX;
    localparam int SUMAD = (RES + 1) % 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] readData;
    logic [3:0]  address;
    logic [15:0] writeData;
    logic        enWrite, enRead, readFile, writeFile, busy, done;
    logic [15:0] max_value;
    logic [3:0]  max_index;
    logic [15:0] sum_value;

    logic [15:0] mem [16];
    logic [15:0] img [16];
    logic        loadEn = 1'b0;

    int errors = 0;
    int checks = 0;
    int expMax, expIdx, expSum;

    mem_reduce_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .readData(readData),
        .address(address), .writeData(writeData), .enWrite(enWrite),
        .enRead(enRead), .readFile(readFile), .writeFile(writeFile),
        .busy(busy), .done(done),
`ifdef MEM_REDUCE_SUM_EN
        .sum_value(sum_value),
`endif
        .max_value(max_value), .max_index(max_index)
    );

`ifndef MEM_REDUCE_SUM_EN
    assign sum_value = 16'h0;
`endif

    always #5 clk = ~clk;

    assign readData = mem[address];

    always @(posedge clk) begin
        if (loadEn) begin
            for (int i = 0; i < 16; i++) mem[i] <= img[i];
        end else if (enWrite) begin
            mem[address] <= writeData;
        end
    end

    wire [5:0] strb = {busy, readFile, enRead, enWrite, writeFile, done};

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain scan of the image with strict-greater max and clamped sum.
    task automatic model();
        int v;
        expMax = 0;
        expIdx = BASE;
        expSum = 0;
        for (int i = 0; i < COUNT; i++) begin
            v = int'(img[BASE + i]);
            if (v > expMax) begin
                expMax = v;
                expIdx = BASE + i;
            end
            expSum = expSum + v;
            if (expSum > 65535) expSum = 65535;
        end
    endtask

    function automatic logic [5:0] expStrb(input int c);
        logic b, rf, er, ew, wf, dn;
        b  = (c >= 1) && (c <= LAT);
        rf = (c == 1);
        er = (c >= 2) && (c <= COUNT + 1);
        ew = (c == COUNT + 2) || ((SUMX == 1) && (c == COUNT + 3));
        wf = (c == LAT - 1);
        dn = (c == LAT);
        return {b, rf, er, ew, wf, dn};
    endfunction

    task automatic loadImg();
        loadEn = 1'b1;
        @(negedge clk);
        loadEn = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkResults();
        checkVal("max_value", 32'(max_value), 32'(expMax));
        checkVal("max_index", 32'(max_index), 32'(expIdx));
        checkVal("mem_result", 32'(mem[RES]), 32'(expMax));
        if (SUMX == 1) begin
            checkVal("sum_value", 32'(sum_value), 32'(expSum));
            checkVal("mem_sum", 32'(mem[SUMAD]), 32'(expSum));
        end
        img[RES] = 16'(expMax);
        if (SUMX == 1) img[SUMAD] = 16'(expSum);
    endtask

    // Called at a negedge with the DUT idle; start is sampled on the next posedge.
    task automatic runScan(input bit hold, input bit poke);
        int k;
        model();
        start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= LAT; c++) begin
            checkVal("strobes", 32'(strb), 32'(expStrb(c)));
            if (c >= 2 && c <= COUNT + 1)
                checkVal("read_addr", 32'(address), 32'(BASE + c - 2));
            if (c == COUNT + 2) begin
                checkVal("write_addr", 32'(address), 32'(RES));
                checkVal("write_data", 32'(writeData), 32'(expMax));
            end
            if (SUMX == 1 && c == COUNT + 3) begin
                checkVal("sum_addr", 32'(address), 32'(SUMAD));
                checkVal("sum_data", 32'(writeData), 32'(expSum));
            end
            if (c == LAT - 1)
                checkVal("dump_addr", 32'(address), 32'(RES));
            if (!hold && c == 1) start = 1'b0;
            if (poke && c == 7) start = 1'b1;
            if (poke && !hold && c == 8) start = 1'b0;
            @(negedge clk);
        end
        checkVal("idle_strobes", 32'(strb), 32'(0));
        checkResults();
        if (hold) begin
            @(negedge clk);
            checkVal("relaunch_load", 32'(strb), 32'(expStrb(1)));
            start = 1'b0;
            model();
            k = 0;
            while (k < LAT + 5 && !done) begin
                @(negedge clk);
                k++;
            end
            checkVal("relaunch_done_cycle", 32'(k), 32'(LAT - 1));
            @(negedge clk);
            checkResults();
        end
    endtask

    task automatic resetMidRun();
        logic [15:0] oldRes;
        oldRes = mem[RES];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checkVal("pre_reset_addr", 32'(address), 32'(BASE + 4));
        #1 rst = 1'b1;
        #1;
        checkVal("rst_strobes", 32'(strb), 32'(0));
        checkVal("rst_outputs", {address, writeData, max_index, 8'h0}, 32'(0));
        checkVal("rst_max", 32'(max_value), 32'(0));
        repeat (3) @(negedge clk);
        checkVal("rst_no_write", 32'(mem[RES]), 32'(oldRes));
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) img[i] = 16'h0;
        img[RES] = 16'h5A5A;
        loadEn = 1'b1;
        repeat (2) @(negedge clk);
        loadEn = 1'b0;
        checkVal("reset_strobes", 32'(strb), 32'(0));
        checkVal("reset_max", {max_value, 12'h0, max_index}, 32'(0));
        checkVal("reset_addr", 32'(address), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        // small values with one clear winner at address 1
        for (int i = 0; i < 15; i++) img[i] = 16'h0;
        img[0] = 16'h0003; img[1] = 16'h00A0; img[2] = 16'h0010;
        loadImg();
        runScan(1'b0, 1'b0);

        // tie at the top value: lower address must win
        for (int i = 0; i < 15; i++) img[i] = 16'($urandom_range(0, 16'hFFFE));
        img[2] = 16'hFFFF; img[9] = 16'hFFFF;
        loadImg();
        runScan(1'b0, 1'b0);

        for (int i = 0; i < 15; i++) img[i] = 16'h0;
        loadImg();
        runScan(1'b0, 1'b0);

        // start poked mid-run and held through DONE
        for (int i = 0; i < 15; i++) img[i] = 16'($urandom);
        loadImg();
        runScan(1'b1, 1'b1);

        for (int i = 0; i < 15; i++) img[i] = 16'($urandom);
        img[RES] = 16'hBEEF;
        loadImg();
        resetMidRun();
        runScan(1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++)
                img[i] = (r % 2 == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            loadImg();
            runScan(1'b0, (r == 4));
        end

        if (SUMX == 1) begin
            for (int i = 0; i < 15; i++) img[i] = 16'h2000;
            loadImg();
            runScan(1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
